// File: rtl/dct_pkg.sv
// Shared 2D-DCT types: block dimension, element width and the packed row/column vector.
package dct_pkg;
  localparam int DCT_N = 8;
  localparam int DCT_W = 16;

  typedef logic [DCT_W-1:0] dct_elem_t;
  typedef dct_elem_t [DCT_N-1:0] dct_vec_t;
endpackage

// File: rtl/dct_tpose_bank.sv
// One 8x8 transpose bank: rows are written whole, columns are read combinationally.
module dct_tpose_bank
  import dct_pkg::*;
(
  input  logic                   clk,
  input  logic                   we_i,
  input  logic [2:0]             wr_row_i,
  input  logic [DCT_N*DCT_W-1:0] wr_vec_i,
  input  logic [2:0]             rd_col_i,
  output logic [DCT_N*DCT_W-1:0] rd_vec_o
);

  dct_vec_t mem_q [DCT_N];

  // Storage only; contents are meaningless until a bank has been filled.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[wr_row_i] <= dct_vec_t'(wr_vec_i);
    end
  end

  always_comb begin
    rd_vec_o = '0;
    for (int r = 0; r < DCT_N; r++) begin
      rd_vec_o[r*DCT_W +: DCT_W] = mem_q[r][rd_col_i];
    end
  end

endmodule

// File: rtl/dct_transpose_buffer.sv
// Row-in / column-out 8x8 transpose buffer between the two 1D DCT passes.
// Define DCT_TPOSE_PINGPONG_EN for two banks in ping-pong; otherwise a single bank.
module dct_transpose_buffer
  import dct_pkg::*;
#(
  parameter int N      = DCT_N,
  parameter int DATA_W = DCT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*DATA_W-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N*DATA_W-1:0] out_data,
  output logic [2:0]          out_col,
  output logic                out_last
);

  logic       wr_bank_q, wr_bank_d;
  logic       rd_bank_q, rd_bank_d;
  logic [2:0] wr_row_q, wr_row_d;
  logic [2:0] rd_col_q, rd_col_d;
  logic [1:0] full_q, full_d;
  logic       wr_fire, rd_fire;

  // Handshake flags depend only on registered state, so in_ready never sees out_ready.
  assign in_ready  = !full_q[wr_bank_q];
  assign out_valid = full_q[rd_bank_q];
  assign out_col   = rd_col_q;
  assign out_last  = out_valid && (rd_col_q == 3'd7);
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;

  always_comb begin
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_row_d  = wr_row_q;
    rd_col_d  = rd_col_q;
    full_d    = full_q;
    // A bank cannot be written and drained in the same cycle: the full flag gates both.
    if (wr_fire) begin
      wr_row_d = wr_row_q + 3'd1;
      if (wr_row_q == 3'd7) begin
        full_d[wr_bank_q] = 1'b1;
`ifdef DCT_TPOSE_PINGPONG_EN
        wr_bank_d = ~wr_bank_q;
`endif
      end
    end
    if (rd_fire) begin
      rd_col_d = rd_col_q + 3'd1;
      if (rd_col_q == 3'd7) begin
        full_d[rd_bank_q] = 1'b0;
`ifdef DCT_TPOSE_PINGPONG_EN
        rd_bank_d = ~rd_bank_q;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_row_q  <= 3'd0;
      rd_col_q  <= 3'd0;
      full_q    <= 2'b00;
    end else begin
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_row_q  <= wr_row_d;
      rd_col_q  <= rd_col_d;
      full_q    <= full_d;
    end
  end

  logic [N*DATA_W-1:0] rd_vec0;

  dct_tpose_bank u_bank0 (
    .clk      (clk),
    .we_i     (wr_fire && !wr_bank_q),
    .wr_row_i (wr_row_q),
    .wr_vec_i (in_data),
    .rd_col_i (rd_col_q),
    .rd_vec_o (rd_vec0)
  );

`ifdef DCT_TPOSE_PINGPONG_EN
  logic [N*DATA_W-1:0] rd_vec1;

  dct_tpose_bank u_bank1 (
    .clk      (clk),
    .we_i     (wr_fire && wr_bank_q),
    .wr_row_i (wr_row_q),
    .wr_vec_i (in_data),
    .rd_col_i (rd_col_q),
    .rd_vec_o (rd_vec1)
  );

  assign out_data = rd_bank_q ? rd_vec1 : rd_vec0;
`else
  assign out_data = rd_vec0;
`endif

endmodule

// File: tb/tb_dct_transpose_buffer.sv
// Self-checking bench for dct_transpose_buffer; follows DCT_TPOSE_PINGPONG_EN like the design.
module tb_dct_transpose_buffer;

`ifdef DCT_TPOSE_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic [2:0]   out_col;
  logic         out_last;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dct_transpose_buffer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_col   (out_col),
    .out_last  (out_last)
  );

  // Reference: blocks are numbered by rows/8 and cols/8 since reset; NB blocks may be outstanding.
  int          m_rows = 0;
  int          m_cols = 0;
  logic [15:0] m_blk [256][8][8];

  function automatic bit m_ready();
    return ((m_rows / 8) - (m_cols / 8)) < NB;
  endfunction

  function automatic bit m_valid();
    return (m_rows / 8) > (m_cols / 8);
  endfunction

  function automatic logic [127:0] m_col();
    logic [127:0] v;
    int b;
    b = (m_cols / 8) % 256;
    for (int r = 0; r < 8; r++) v[r*16 +: 16] = m_blk[b][r][m_cols % 8];
    return v;
  endfunction

  function automatic logic [127:0] rand_row();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] pat_row(input int r);
    logic [127:0] v;
    for (int c = 0; c < 8; c++) v[c*16 +: 16] = {4'h0, 4'(r), 4'(c), 4'h0};
    return v;
  endfunction

  // Drive one cycle and advance the reference by what the handshake rules say happens at the edge.
  task automatic step(input logic iv, input logic [127:0] d, input logic ordy);
    bit ai, ao;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    ai = iv && m_ready();
    ao = ordy && m_valid();
    @(posedge clk);
    #1;
    if (ao) m_cols++;
    if (ai) begin
      for (int k = 0; k < 8; k++) m_blk[(m_rows / 8) % 256][m_rows % 8][k] = d[k*16 +: 16];
      m_rows++;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    m_rows = 0;
    m_cols = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (out_col !== 3'd0) begin failures++; $display("FAIL reset_out_col got=%0d want=0", out_col); end
    checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%b want=0", out_last); end
  endtask

  task automatic test_single_block();
    logic [15:0] want;
    for (int r = 0; r < 8; r++) begin
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL sb_early_valid row=%0d got=%b want=0", r, out_valid); end
      step(1'b1, pat_row(r), 1'b1);
    end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL sb_latency got=%b want=1", out_valid); end
    for (int c = 0; c < 8; c++) begin
      checks++; if (out_col !== 3'(c)) begin failures++; $display("FAIL sb_col got=%0d want=%0d", out_col, c); end
      checks++; if (out_last !== (c == 7)) begin failures++; $display("FAIL sb_last col=%0d got=%b want=%b", c, out_last, c == 7); end
      for (int r = 0; r < 8; r++) begin
        want = {4'h0, 4'(r), 4'(c), 4'h0};
        checks++;
        if (out_data[r*16 +: 16] !== want) begin
          failures++; $display("FAIL sb_data col=%0d lane=%0d got=%h want=%h", c, r, out_data[r*16 +: 16], want);
        end
      end
      step(1'b0, '0, 1'b1);
    end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL sb_drained got=%b want=0", out_valid); end
  endtask

`ifdef DCT_TPOSE_PINGPONG_EN
  task automatic test_back_to_back();
    int ncol = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready cyc=%0d got=%b want=1", cyc, in_ready); end
      checks++; if (out_valid !== m_valid()) begin failures++; $display("FAIL b2b_valid cyc=%0d got=%b want=%b", cyc, out_valid, m_valid()); end
      if (m_valid()) begin
        ncol++;
        checks++; if (out_col !== 3'(m_cols % 8)) begin failures++; $display("FAIL b2b_col got=%0d want=%0d", out_col, m_cols % 8); end
        checks++; if (out_data !== m_col()) begin failures++; $display("FAIL b2b_data got=%h want=%h", out_data, m_col()); end
      end
      step(cyc < 32, rand_row(), 1'b1);
    end
    checks++; if (ncol != 32) begin failures++; $display("FAIL b2b_count got=%0d want=32", ncol); end
  endtask

  task automatic test_backpressure();
    logic [127:0] held;
    for (int r = 0; r < 8; r++) step(1'b1, rand_row(), 1'b0);
    held = m_col();
    for (int cyc = 0; cyc < 20; cyc++) begin
      checks++; if (out_data !== held) begin failures++; $display("FAIL bp_hold cyc=%0d got=%h want=%h", cyc, out_data, held); end
      checks++; if (out_col !== 3'd0) begin failures++; $display("FAIL bp_col cyc=%0d got=%0d want=0", cyc, out_col); end
      checks++; if (in_ready !== m_ready()) begin failures++; $display("FAIL bp_in_ready cyc=%0d got=%b want=%b", cyc, in_ready, m_ready()); end
      step(1'b1, rand_row(), 1'b0);
    end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_stalled got=%b want=0", in_ready); end
    for (int cyc = 0; cyc < 40 && m_valid(); cyc++) begin
      checks++; if (in_ready !== m_ready()) begin failures++; $display("FAIL bp_recover cyc=%0d got=%b want=%b", cyc, in_ready, m_ready()); end
      checks++; if (out_data !== m_col()) begin failures++; $display("FAIL bp_data got=%h want=%h", out_data, m_col()); end
      step(1'b0, '0, 1'b1);
    end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drained got=%b want=0", out_valid); end
  endtask
`else
  task automatic test_single_bank();
    int base_rows, base_cols, cyc, lows;
    base_rows = m_rows;
    base_cols = m_cols;
    cyc = 0;
    lows = 0;
    while ((m_cols - base_cols) < 16 && cyc < 100) begin
      if (in_ready === 1'b0) lows++;
      checks++; if (in_ready !== m_ready()) begin failures++; $display("FAIL sbk_in_ready cyc=%0d got=%b want=%b", cyc, in_ready, m_ready()); end
      if (m_valid()) begin
        checks++; if (out_data !== m_col()) begin failures++; $display("FAIL sbk_data got=%h want=%h", out_data, m_col()); end
      end
      step((m_rows - base_rows) < 16, rand_row(), 1'b1);
      cyc++;
    end
    checks++; if (cyc != 32) begin failures++; $display("FAIL sbk_cycles got=%0d want=32", cyc); end
    checks++; if (lows != 16) begin failures++; $display("FAIL sbk_low_cycles got=%0d want=16", lows); end
  endtask
`endif

  task automatic test_reset_mid_fill();
    for (int r = 0; r < 13; r++) step(1'b1, rand_row(), 1'b0);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rmf_pre_valid got=%b want=1", out_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rmf_out_valid got=%b want=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rmf_in_ready got=%b want=1", in_ready); end
    checks++; if (out_col !== 3'd0) begin failures++; $display("FAIL rmf_out_col got=%0d want=0", out_col); end
    apply_reset();
    for (int r = 0; r < 8; r++) step(1'b1, rand_row(), 1'b0);
    for (int c = 0; c < 8; c++) begin
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rmf_valid col=%0d got=%b want=1", c, out_valid); end
      checks++; if (out_data !== m_col()) begin failures++; $display("FAIL rmf_data col=%0d got=%h want=%h", c, out_data, m_col()); end
      step(1'b0, '0, 1'b1);
    end
  endtask

  task automatic test_random();
    int target, cyc;
    target = m_cols + 800;
    cyc = 0;
    while (m_cols < target && cyc < 20000) begin
      checks++; if (in_ready !== m_ready()) begin failures++; $display("FAIL rnd_in_ready cyc=%0d got=%b want=%b", cyc, in_ready, m_ready()); end
      checks++; if (out_valid !== m_valid()) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%b want=%b", cyc, out_valid, m_valid()); end
      if (m_valid()) begin
        checks++; if (out_col !== 3'(m_cols % 8)) begin failures++; $display("FAIL rnd_col got=%0d want=%0d", out_col, m_cols % 8); end
        checks++; if (out_last !== ((m_cols % 8) == 7)) begin failures++; $display("FAIL rnd_last got=%b want=%b", out_last, (m_cols % 8) == 7); end
        checks++; if (out_data !== m_col()) begin failures++; $display("FAIL rnd_data got=%h want=%h", out_data, m_col()); end
      end
      step($urandom_range(0, 9) < 7, rand_row(), $urandom_range(0, 9) < 6);
      cyc++;
    end
    checks++; if (m_cols < target) begin failures++; $display("FAIL rnd_timeout got=%0d want=%0d", m_cols, target); end
  endtask

  initial begin
    test_reset();
    test_single_block();
`ifdef DCT_TPOSE_PINGPONG_EN
    test_back_to_back();
    test_backpressure();
`else
    test_single_bank();
`endif
    test_reset_mid_fill();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
